// File: rtl/seg7_scan_driver_if.sv
// Upstream-to-scanner bundle: the seven digit patterns plus load/enable controls.
// The register stage drives the master side; the scan driver reads the slave side.
interface seg7_scan_driver_if;
   logic [6:0] input1;
   logic [6:0] input2;
   logic [6:0] input3;
   logic [6:0] input4;
   logic [6:0] input5;
   logic [6:0] input6;
   logic [6:0] input7;
   logic       load;
   logic       enable;

   modport master (output input1, input2, input3, input4, input5, input6, input7,
                   output load, enable);
   modport slave  (input  input1, input2, input3, input4, input5, input6, input7,
                   input  load, enable);
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-digit display scanner: a shadow bank of seven patterns, shown one
// digit per DIV-cycle slot, with BLANK leading off-cycles per slot to suppress ghosting.
module seg7_scan_driver #(
   parameter int DIV            = 4,
   parameter int BLANK          = 1,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                clk,
   input  logic                reset,
   seg7_scan_driver_if.slave   bus,
   output logic [6:0]          seg,
   output logic [6:0]          dig_sel,
   output logic [2:0]          scan_idx,
   output logic                frame_done
);
   localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  C_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0]  C_BLAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
   localparam logic [6:0]     C_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

   state_t              r_state, w_state;
   logic [CW-1:0]       r_cnt,   w_cnt;
   logic [2:0]          r_idx,   w_idx;
   logic [6:0][6:0]     r_sh,    w_sh;
   logic                r_pend,  w_pend;
   logic [6:0]          r_seg,   w_seg;
   logic [6:0]          r_dig,   w_dig;
   logic                r_fd,    w_fd;
   logic [6:0][6:0]     w_in;
   state_t              w_slot_start;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_sh    <= '0;
         r_pend  <= 1'b0;
         r_seg   <= C_OFF;
         r_dig   <= '0;
         r_fd    <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_sh    <= w_sh;
         r_pend  <= w_pend;
         r_seg   <= w_seg;
         r_dig   <= w_dig;
         r_fd    <= w_fd;
      end
   end

   always_comb begin
      w_in         = {bus.input7, bus.input6, bus.input5, bus.input4,
                      bus.input3, bus.input2, bus.input1};
      w_slot_start = (BLANK > 0) ? S_BLANK : S_SHOW;
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_idx        = r_idx;
      w_sh         = r_sh;
      w_pend       = r_pend;
      w_fd         = 1'b0;

      if (!bus.enable) begin
         // Parking the scanner is also a safe point to apply any deferred load.
         w_state = S_IDLE;
         w_cnt   = '0;
         w_idx   = '0;
         if (r_pend || bus.load) w_sh = w_in;
         w_pend  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.load) w_sh = w_in;
               w_cnt   = '0;
               w_idx   = '0;
               w_state = w_slot_start;
            end
            S_BLANK: begin
               if (bus.load) w_pend = 1'b1;
               w_cnt = r_cnt + 1'b1;
               if (r_cnt == C_BLAST) w_state = S_SHOW;
            end
            S_SHOW: begin
               if (bus.load) w_pend = 1'b1;
               if (r_cnt == C_LAST) begin
                  w_cnt   = '0;
                  w_state = w_slot_start;
                  if (r_idx == 3'd6) begin
                     // Frame wrap: only here may the bank change, so no frame mixes data.
                     w_idx  = '0;
                     w_fd   = 1'b1;
                     if (r_pend || bus.load) w_sh = w_in;
                     w_pend = 1'b0;
                  end else begin
                     w_idx = r_idx + 3'd1;
                  end
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
            end
            default: w_state = S_IDLE;
         endcase
      end

      w_seg = C_OFF;
      w_dig = '0;
      if (w_state == S_SHOW) begin
         w_dig = 7'd1 << w_idx;
         w_seg = w_sh[w_idx] ^ C_OFF;
      end
   end

   assign seg        = r_seg;
   assign dig_sel    = r_dig;
   assign scan_idx   = r_idx;
   assign frame_done = r_fd;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: default scanner (A) and BLANK=0/active-low variant (B) share one stimulus bus.
module tb_seg7_scan_driver;
   logic       clk;
   logic       reset;
   logic [6:0] seg_a, dig_a, seg_b, dig_b;
   logic [2:0] idx_a, idx_b;
   logic       fd_a, fd_b;
   int         n_cmp;
   int         n_err;
   logic [6:0] ex [7];

   seg7_scan_driver_if u_if ();

   seg7_scan_driver u_dut_a (
      .clk(clk), .reset(reset), .bus(u_if),
      .seg(seg_a), .dig_sel(dig_a), .scan_idx(idx_a), .frame_done(fd_a));

   seg7_scan_driver #(.DIV(4), .BLANK(0), .SEG_ACTIVE_LOW(1)) u_dut_b (
      .clk(clk), .reset(reset), .bus(u_if),
      .seg(seg_b), .dig_sel(dig_b), .scan_idx(idx_b), .frame_done(fd_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k counts cycles after the start (or previous wrap) edge; slot s = (k-1)/4.
   task automatic run_frame(input bit first, input int load_at, input int stop_at);
      int         s, p;
      logic [6:0] e_dig, e_seg, v_seg;
      for (int k = 1; k <= stop_at; k++) begin
         tick();
         if (k == load_at + 1) u_if.load = 1'b0;
         s     = (k - 1) / 4;
         p     = (k - 1) % 4;
         e_dig = 7'd1 << s;
         e_seg = ex[s];
         v_seg = ~ex[s];
         check("a_dig", dig_a, (p == 0) ? 7'd0 : e_dig);
         check("a_seg", seg_a, (p == 0) ? 7'd0 : e_seg);
         check("a_idx", idx_a, s);
         check("a_fd",  fd_a,  (k == 1 && !first) ? 1 : 0);
         check("b_dig", dig_b, e_dig);
         check("b_seg", seg_b, v_seg);
         check("b_fd",  fd_b,  (k == 1 && !first) ? 1 : 0);
         if (k == load_at) u_if.load = 1'b1;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      u_if.enable = 1'b1;
      u_if.load   = 1'b0;
      {u_if.input1, u_if.input2, u_if.input3, u_if.input4,
       u_if.input5, u_if.input6, u_if.input7} = '0;

      // Held in reset with enable high: everything stays off.
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_a", {seg_a, dig_a, idx_a, fd_a}, 18'h0);
         check("rst_b", {seg_b, dig_b, idx_b, fd_b}, {7'h7F, 11'h0});
      end

      u_if.enable = 1'b0;
      reset = 1'b1;
      tick();
      check("idle_b_seg", seg_b, 7'h7F);
      check("idle_a_dig", dig_a, 7'h00);

      // Load in IDLE, then start scanning.
      u_if.input1 = 7'h3F; u_if.input2 = 7'h06; u_if.input3 = 7'h5B; u_if.input4 = 7'h4F;
      u_if.input5 = 7'h66; u_if.input6 = 7'h6D; u_if.input7 = 7'h7D;
      u_if.load = 1'b1;
      tick();
      u_if.load = 1'b0;
      check("idle_load_a_dig", dig_a, 7'h00);
      ex[0] = 7'h3F; ex[1] = 7'h06; ex[2] = 7'h5B; ex[3] = 7'h4F;
      ex[4] = 7'h66; ex[5] = 7'h6D; ex[6] = 7'h7D;
      u_if.enable = 1'b1;
      run_frame(1'b1, 0, 28);

      // Mid-frame load in slot 2 (input1 held at 7'h07); old data until the wrap.
      u_if.input1 = 7'h07;
      run_frame(1'b0, 10, 28);
      ex[0] = 7'h07;
      run_frame(1'b0, 0, 28);

      // Drop enable in cycle 3 of slot 3.
      run_frame(1'b0, 0, 15);
      u_if.enable = 1'b0;
      tick();
      check("drop_a", {seg_a, dig_a, idx_a, fd_a}, 18'h0);
      check("drop_b", {seg_b, dig_b, idx_b}, {7'h7F, 10'h0});
      tick();
      check("parked_a_dig", dig_a, 7'h00);
      u_if.enable = 1'b1;
      run_frame(1'b1, 0, 6);

      // Asynchronous reset between edges while slot 1 is showing.
      check("pre_rst_a_dig", dig_a, 7'h02);
      #2 reset = 1'b0;
      #1;
      check("arst_a_dig", dig_a, 7'h00);
      check("arst_a_seg", seg_a, 7'h00);
      check("arst_a_idx", idx_a, 3'd0);
      check("arst_b_seg", seg_b, 7'h7F);
      check("arst_b_dig", dig_b, 7'h00);
      u_if.enable = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("rel_a_dig", dig_a, 7'h00);

      // Restart without a load: cleared shadow bank shows as blank patterns.
      for (int i = 0; i < 7; i++) ex[i] = 7'h00;
      u_if.enable = 1'b1;
      run_frame(1'b1, 0, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
